// File: rtl/switch_debouncer.sv
`default_nettype none
// ============================================================================
// Module      : switch_debouncer
// Description : Per-bit synchronizer and debouncer for the board DIP switches.
//               It adds a change pulse and a sticky change flag that a port read clears.
// Revision    : 1.0 - initial release
// ============================================================================
module switch_debouncer #(
    parameter int WIDTH           = 16,
    parameter int DEBOUNCE_CYCLES = 10000
) (
    input  logic             clk,
    input  logic             isReset,
    input  logic [WIDTH-1:0] sw_in,
    input  logic             isCS,
    input  logic             isW,
    output logic [WIDTH-1:0] data,
    output logic             changed,
    output logic             isChanged
);

    localparam int                c_cntWidth = $clog2(DEBOUNCE_CYCLES);
    localparam logic [c_cntWidth-1:0] c_cntMax = c_cntWidth'(DEBOUNCE_CYCLES - 1);

    logic [WIDTH-1:0]      r_s1;
    logic [WIDTH-1:0]      r_s2;
    logic [WIDTH-1:0]      r_data;
    logic [c_cntWidth-1:0] r_cnt [WIDTH];
    logic                  r_changed;
    logic                  r_isChanged;

    logic [WIDTH-1:0]      w_update;
    logic                  w_anyUpdate;
    logic                  w_read;

    // A bit commits on the edge where its mismatch has lasted DEBOUNCE_CYCLES cycles.
    always_comb begin
        w_update = '0;
        for (int i = 0; i < WIDTH; i++) begin
            w_update[i] = (r_s2[i] != r_data[i]) && (r_cnt[i] == c_cntMax);
        end
    end

    assign w_anyUpdate = |w_update;
    assign w_read      = isCS && !isW;

    always_ff @(posedge clk) begin
        if (isReset) begin
            r_s1        <= '0;
            r_s2        <= '0;
            r_data      <= '0;
            r_changed   <= 1'b0;
            r_isChanged <= 1'b0;
            for (int i = 0; i < WIDTH; i++) begin
                r_cnt[i] <= '0;
            end
        end else begin
            r_s1 <= sw_in;
            r_s2 <= r_s1;
            for (int i = 0; i < WIDTH; i++) begin
                if (r_s2[i] == r_data[i]) begin
                    r_cnt[i] <= '0;
                end else if (w_update[i]) begin
                    r_data[i] <= r_s2[i];
                    r_cnt[i]  <= '0;
                end else begin
                    r_cnt[i] <= r_cnt[i] + 1'b1;
                end
            end
            r_changed <= w_anyUpdate;
            // Set beats clear so an update coinciding with a read is not lost.
            if (w_anyUpdate) begin
                r_isChanged <= 1'b1;
            end else if (w_read) begin
                r_isChanged <= 1'b0;
            end
        end
    end

    assign data      = r_data;
    assign changed   = r_changed;
    assign isChanged = r_isChanged;

endmodule
`default_nettype wire

// File: doc/switch_debouncer.md
Name: switch_debouncer

Overview:
- Conditions the raw board DIP switches before they reach the Minisys-1 switch I/O port.
- Synchronizes each asynchronous switch bit into the CPU clock domain and debounces it per bit.
- Presents a stable 16-bit word on `data`, which feeds the switch port's read-data input.
- Provides a one-cycle change pulse and a sticky change flag. The flag is cleared when the CPU reads the switch port.

Parameters:
- WIDTH, 16, number of switch bits.
- DEBOUNCE_CYCLES, 10000, consecutive clock cycles a synchronized bit must differ from `data` before `data` takes the new value. Must be ≥2. Benches override it to 4.

Ports:
- clk  input  1  system clock; the only clock.
- isReset  input  1  synchronous, active-high reset.
- sw_in  input  WIDTH  raw switch levels; asynchronous to clk.
- isCS  input  1  switch-port chip select from the address decoder.
- isW  input  1  write strobe; a read is isCS && ~isW.
- data  output  WIDTH  debounced switch word; registered.
- changed  output  1  one-cycle pulse when any bit of data updates.
- isChanged  output  1  sticky change flag; cleared by a port read.

Behaviour:
- All state updates on the rising edge of clk. Reset is sampled only on that edge.
- Reset (isReset=1):
  - sync stages s1 and s2, all per-bit counters, data, changed and isChanged go to 0.
  - Reset takes priority over all other activity.
  - Reset mid-debounce discards the partial count. After reset, any switch held high is debounced again from data=0.
- Synchronizer: s1<=sw_in, s2<=s1 every cycle. data never samples sw_in or s1 directly.
- Per bit i, each bit has its own counter cnt[i], width $clog2(DEBOUNCE_CYCLES):
  - If s2[i]==data[i]: cnt[i]<=0.
  - Else if cnt[i]==DEBOUNCE_CYCLES-1: data[i]<=s2[i] and cnt[i]<=0.
  - Else: cnt[i]<=cnt[i]+1.
- Latency: sw_in changes before edge k and then holds. data shows the new value after edge k+DEBOUNCE_CYCLES+1, which is edge k+5 for N=4.
- Glitch rejection: if the s2 mismatch returns to a match before reaching DEBOUNCE_CYCLES consecutive cycles, the counter clears and data does not change. Bounce therefore restarts the count.
- Bits are independent. Several bits may update on the same edge, and `changed` still pulses once.
- changed: registered. It is 1 for exactly the cycle after any data bit updates (same edge as the data update), otherwise 0.
- isChanged:
  - Set on any edge where a data bit updates.
  - Cleared on an edge where isCS=1 and isW=0.
  - If an update and a read coincide on the same edge, set wins, so no event is lost.
  - Holds otherwise.
  - Writes (isCS && isW) have no effect.
- data is never high-impedance. Bus tristating is the switch port's responsibility.
- No arithmetic overflow: a counter never exceeds DEBOUNCE_CYCLES-1.

Test Plan (DEBOUNCE_CYCLES=4, WIDTH=16):
- Reset then clean step:
  - Stimulus: isReset=1 for 2 cycles, then sw_in=16'h00A5 held from before edge k.
  - Required: data=16'h0000 through edge k+4, data=16'h00A5 after edge k+5, changed=1 for exactly that one cycle, isChanged=1 afterwards.
- Bounce rejection:
  - Stimulus: starting from data=0, bit 3 toggles 1,0,1,0 every 2 cycles, then settles at 0.
  - Required: data stays 16'h0000, changed never asserts, isChanged stays 0.
- Bounce then settle:
  - Stimulus: bit 15 toggles for 3 cycles, then holds 1.
  - Required: data=16'h8000 exactly 5 edges after the last toggle is applied, with a single changed pulse.
- Read clears flag:
  - Stimulus: with isChanged=1, assert isCS=1, isW=0 for one cycle.
  - Required: isChanged=0 on the next cycle. A repeat with isCS=1, isW=1 leaves isChanged=1.
- Simultaneous update and read:
  - Stimulus: time the read edge to coincide with the data update edge of sw_in 16'h0000→16'h0001.
  - Required: isChanged=1 after that edge, and data=16'h0001.
- Reset mid-debounce:
  - Stimulus: sw_in=16'hFFFF, then isReset=1 for 1 cycle 2 edges before the expected update, then released.
  - Required: data=16'h0000 immediately after reset, and data=16'hFFFF only DEBOUNCE_CYCLES+1 edges after the release edge.
